// File: rtl/alu_cmd_pkg.sv
// alu_cmd_pkg: shared types and constants for the ALU command assembler
// Provides the opcode enum, the 10-bit {op,b,a} command word, the header sync marker and FSM states.
package alu_cmd_pkg;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} alu_op_t;
    typedef struct packed {
        alu_op_t    op;
        logic [3:0] b;
        logic [3:0] a;
    } alu_cmd_t;
    localparam logic [1:0] SYNC = 2'b10;
    typedef enum logic {S_HDR, S_OPND} state_t;
endpackage

// File: rtl/cmd_skid_buf.sv
// cmd_skid_buf: small FIFO of command words between byte intake and the downstream consumer
// Ports: clk/reset (sync, high); push/push_data write the tail; out_data/out_valid present the head,
// popped when out_ready; count is the current fill level. DEPTH must be a power of two.
module cmd_skid_buf
    import alu_cmd_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  alu_cmd_t                       push_data,
    input  logic                           out_ready,
    output alu_cmd_t                       out_data,
    output logic                           out_valid,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    alu_cmd_t        mem_q [DEPTH];
    alu_cmd_t        mem_d [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pop;
    always_comb begin
        mem_d        = mem_q;
        pop          = count_q != '0 && out_ready;
        mem_d[wr_q]  = push ? push_data : mem_q[wr_q];
        wr_d         = wr_q + PW'(push);
        rd_d         = rd_q + PW'(pop);
        count_d      = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
    assign out_data  = mem_q[rd_q];
    assign out_valid = count_q != '0;
    assign count     = count_q;
endmodule

// File: rtl/alu_cmd_assembler.sv
// alu_cmd_assembler: frames a header/operand byte stream into {op,b,a} ALU command words
// Ports: clk/reset (sync, high); in_byte/in_valid/in_ready byte intake; out_data/out_valid/out_ready
// command output; frame_err/divz_err/tmo_err one-cycle drop pulses; cmd_cnt/drop_cnt saturating stats.
module alu_cmd_assembler
    import alu_cmd_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [9:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             divz_err,
    output logic             tmo_err,
    output logic [CNT_W-1:0] cmd_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t            state_q, state_d;
    alu_op_t           op_q, op_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d, drop_cnt_q, drop_cnt_d;
    logic              frame_err_q, frame_err_d, divz_err_q, divz_err_d, tmo_err_q, tmo_err_d;
    logic [1:0]        count;
    logic              acc, sync_ok, divz, tmo, push, drop;
    alu_cmd_t          push_data, head;
    always_comb begin
        // Only the registered fill level gates intake, so a same-cycle pop never frees a slot.
        in_ready    = state_q == S_HDR || count < 2'd2;
        acc         = in_valid && in_ready;
        sync_ok     = in_byte[7:6] == SYNC;
        divz        = op_q == OP_DIV && in_byte[7:4] == 4'd0;
        tmo         = state_q == S_OPND && !acc && timer_q == TW'(TIMEOUT - 1);
        frame_err_d = state_q == S_HDR && acc && !sync_ok;
        divz_err_d  = state_q == S_OPND && acc && divz;
        tmo_err_d   = tmo;
        push        = state_q == S_OPND && acc && !divz;
        push_data   = {op_q, in_byte};
        drop        = frame_err_d || divz_err_d || tmo_err_d;
        state_d     = state_q == S_HDR ? (acc && sync_ok ? S_OPND : S_HDR)
                                       : (acc || tmo ? S_HDR : S_OPND);
        op_d        = state_q == S_HDR && acc ? alu_op_t'(in_byte[1:0]) : op_q;
        timer_d     = state_q == S_OPND && !acc && !tmo ? timer_q + TW'(1) : '0;
        cmd_cnt_d   = push && cmd_cnt_q != '1 ? cmd_cnt_q + CNT_W'(1) : cmd_cnt_q;
        drop_cnt_d  = drop && drop_cnt_q != '1 ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HDR;
            op_q        <= OP_ADD;
            timer_q     <= '0;
            cmd_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            frame_err_q <= 1'b0;
            divz_err_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            timer_q     <= timer_d;
            cmd_cnt_q   <= cmd_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            frame_err_q <= frame_err_d;
            divz_err_q  <= divz_err_d;
            tmo_err_q   <= tmo_err_d;
        end
    end
    cmd_skid_buf #(.DEPTH(2)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .out_ready (out_ready),
        .out_data  (head),
        .out_valid (out_valid),
        .count     (count)
    );
    assign out_data  = head;
    assign frame_err = frame_err_q;
    assign divz_err  = divz_err_q;
    assign tmo_err   = tmo_err_q;
    assign cmd_cnt   = cmd_cnt_q;
    assign drop_cnt  = drop_cnt_q;
endmodule
